fifo_pack_reader: RTL and testbench
===================================

Name: fifo_pack_reader

Overview:
- Drain stage placed directly downstream of a sync_fifo instance (EOF=1 build).
- Pops narrow words using the FIFO's r_en/valid protocol, which has 1-cycle read latency.
- Packs RATIO consecutive words into one wide word and presents it on a valid/ready output.
- On FIFO eof, flushes any partial word (tagged last, keep mask) and raises done; feeds wide-word consumers such as the hash-input formatter.

Parameters:
- WIDTH, 8: bit width of one FIFO word.
- RATIO, 4: FIFO words per output word; legal range 1..16.
- CNT_W, 32: width of the output-word counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- fifo_r_en  out  1  pop request to FIFO.
- fifo_data  in  WIDTH  FIFO data_out; meaningful when fifo_valid=1.
- fifo_valid  in  1  FIFO valid; 1 cycle after an executed pop.
- fifo_empty  in  1  FIFO empty flag.
- fifo_eof  in  1  FIFO eof flag; sticky.
- out_data  out  WIDTH*RATIO  packed word; first-popped word in bits [WIDTH-1:0].
- out_keep  out  RATIO  bit i=1 when slot i holds real data.
- out_last  out  1  marks the flushed partial word.
- out_valid  out  1  out_* holds a word.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- done  out  1  sticky; stream fully drained.
- err  out  1  sticky; protocol violation seen.
- word_count  out  CNT_W  accepted output words.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (async assert, any cycle, including mid-packing) clears every register:
  - all out_* = 0; done = 0; err = 0; word_count = 0; fifo_r_en = 0.
  - idx = 0; inflight = 0; acc = 0; state = FILL.
- Internal state:
  - acc register: WIDTH*RATIO bits.
  - idx: 0..RATIO, number of words held in acc.
  - inflight: 1 bit, a pop has been issued and its data is not yet returned.
  - output register: out_*.
  - state: FILL, FLUSH, DONE.
- fifo_r_en is combinational:
  - = (state==FILL) && !fifo_empty && !fifo_eof && (idx + inflight < RATIO).
  - inflight <= fifo_r_en each cycle.
- Capture: when fifo_valid=1, acc slot idx <= fifo_data, keep bit idx set, idx <= idx+1.
- fifo_valid with inflight=0, or with idx==RATIO: set err; data is dropped; idx unchanged.
- Transfer acc to output register occurs when idx==RATIO && (!out_valid || out_ready):
  - out_data <= acc; out_keep <= all ones; out_last <= 0; out_valid <= 1.
  - idx <= 0; acc <= 0.
  - A capture cannot coincide with a transfer, because the credit rule guarantees it.
- Output handshake:
  - out_valid=1 with out_ready=0: out_* hold stable.
  - Acceptance with no new transfer in the same cycle: out_valid <= 0.
  - Each acceptance increments word_count; it wraps modulo 2^CNT_W.
- Throughput: back-to-back non-empty FIFO gives RATIO words per RATIO+2 cycles. Example, RATIO=4:
  - pops at t0..t3; captures t1..t4; transfer at t5; next pop at t6.
- FILL -> FLUSH when fifo_eof=1 && inflight==0 && fifo_valid==0 && idx<RATIO.
  - When idx==RATIO, the normal transfer happens first and the condition is re-evaluated.
- FLUSH:
  - idx>0: when (!out_valid || out_ready), load out_data <= acc (unused slots 0), out_keep <= low idx bits set, out_last <= 1, out_valid <= 1; idx <= 0; go to DONE.
  - idx==0: go to DONE directly; no empty last word is emitted.
- DONE:
  - done <= 1 once out_valid==0 (last word accepted).
  - No further pops; state held until reset.
- fifo_eof is never expected to rise while inflight=1. If it does, the in-flight word is still captured before FLUSH.

Test Plan:
- RATIO=4, WIDTH=8; write 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88 then eof; out_ready=1 -> two words 0x44332211 and 0x88776655, both keep=0xF, last=0; done=1; word_count=2; no last word.
- Same settings, 6 bytes 0x01..0x06 then eof -> 0x04030201 keep=0xF last=0, then 0x00000605 keep=0x3 last=1; done=1; word_count=2.
- Hold out_ready=0 after the first word is ready, FIFO holding 8 bytes -> second acc fills (idx=4) with fifo_r_en=0 thereafter; out_data stays 0x44332211 stable; release ready -> second word follows on the next cycle.
- Back-to-back streaming of 16 bytes, out_ready=1 -> out_valid pulses every 6 cycles; no pop issued while idx+inflight==4; err=0.
- Assert rst for 1 cycle with idx=2 and inflight=1 -> all outputs 0 immediately (async); stale fifo_valid on the next cycle sets err=1.
- Empty stream: eof with no data -> done=1 within 3 cycles; out_valid never asserted; word_count=0.

Source files
------------

// File: rtl/fifo_pack_reader.sv
// fifo_pack_reader: drains a sync_fifo (1-cycle read latency, sticky eof).
// It packs RATIO narrow words into one wide word on a valid/ready output.
// On eof any partial word is flushed with a keep mask and last=1, then done rises.
module fifo_pack_reader #(
  parameter int WIDTH = 8,
  parameter int RATIO = 4,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     fifo_r_en,
  input  logic [WIDTH-1:0]         fifo_data,
  input  logic                     fifo_valid,
  input  logic                     fifo_empty,
  input  logic                     fifo_eof,
  output logic [WIDTH*RATIO-1:0]   out_data,
  output logic [RATIO-1:0]         out_keep,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     done,
  output logic                     err,
  output logic [CNT_W-1:0]         word_count
);

  localparam int              IDX_W    = $clog2(RATIO + 1);
  localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(RATIO);

  typedef enum logic [1:0] {ST_FILL, ST_FLUSH, ST_DONE} state_t;

  state_t                         state;
  state_t                         state_nxt;
  logic [RATIO-1:0][WIDTH-1:0]    acc;
  logic [IDX_W-1:0]               idx;
  logic                           inflight;

  logic                           full;
  logic                           out_free;
  logic                           accept;
  logic                           capture;
  logic                           bad_valid;
  logic                           transfer;
  logic                           flush_load;
  logic [RATIO-1:0]               part_keep;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) state <= ST_FILL;
    else     state <= state_nxt;
  end

  // Next-state logic: leave FILL only once nothing is in flight and the
  // accumulator is not full (a full accumulator transfers first).
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned,
    // which would otherwise infer a latch.
    state_nxt = state;
    case (state)
      ST_FILL:  if (fifo_eof && !inflight && !fifo_valid && !full) state_nxt = ST_FLUSH;
      ST_FLUSH: if ((idx == '0) || out_free) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_DONE;
      default:  state_nxt = ST_FILL;
    endcase
  end

  // Output/strobe logic: pop credit, capture, transfer and flush decisions.
  always_comb begin
    full      = (idx == IDX_FULL);
    out_free  = !out_valid || out_ready;
    accept    = out_valid && out_ready;
    // A pop is issued only while the held plus in-flight words leave room.
    fifo_r_en = !rst && (state == ST_FILL) && !fifo_empty && !fifo_eof &&
                (({1'b0, idx} + (IDX_W+1)'(inflight)) < (IDX_W+1)'(RATIO));
    capture    = fifo_valid && inflight && !full;
    bad_valid  = fifo_valid && (!inflight || full);
    transfer   = full && out_free;
    flush_load = (state == ST_FLUSH) && (idx != '0) && out_free;
    part_keep  = '0;
    for (int i = 0; i < RATIO; i++) begin
      part_keep[i] = (IDX_W'(i) < idx);
    end
  end

  // Datapath: accumulator, output register, status flags and word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight   <= 1'b0;
      idx        <= '0;
      // NOTE: acc is reset too, so a flushed partial word carries zeros in
      // its unused slots even right after reset.
      acc        <= '0;
      out_data   <= '0;
      out_keep   <= '0;
      out_last   <= 1'b0;
      out_valid  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
    end else begin
      inflight <= fifo_r_en;

      if (bad_valid) err <= 1'b1;
      if (accept)    word_count <= word_count + CNT_W'(1);

      if (transfer || flush_load) begin
        out_data  <= acc;
        out_keep  <= transfer ? '1 : part_keep;
        out_last  <= flush_load;
        out_valid <= 1'b1;
        idx       <= '0;
        acc       <= '0;
      end else begin
        if (accept) out_valid <= 1'b0;
        if (capture) begin
          for (int i = 0; i < RATIO; i++) begin
            if (idx == IDX_W'(i)) acc[i] <= fifo_data;
          end
          idx <= idx + IDX_W'(1);
        end
      end

      if ((state == ST_DONE) && !out_valid) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_pack_reader.sv
// tb_fifo_pack_reader: drives fifo_pack_reader from a queue-based FIFO model
// with 1-cycle read latency and compares accepted words to a chunking model.
module tb_fifo_pack_reader;

  localparam int W  = 8;
  localparam int R  = 4;
  localparam int CW = 32;

  typedef struct packed {
    logic           last;
    logic [R-1:0]   keep;
    logic [W*R-1:0] data;
  } word_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           fifo_r_en;
  logic [W-1:0]   fifo_data = '0;
  logic           fifo_valid = 1'b0;
  logic           fifo_empty = 1'b1;
  logic           fifo_eof = 1'b0;
  logic [W*R-1:0] out_data;
  logic [R-1:0]   out_keep;
  logic           out_last;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic           done;
  logic           err;
  logic [CW-1:0]  word_count;

  always #5 clk = ~clk;

  fifo_pack_reader #(.WIDTH(W), .RATIO(R), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_r_en  (fifo_r_en),
    .fifo_data  (fifo_data),
    .fifo_valid (fifo_valid),
    .fifo_empty (fifo_empty),
    .fifo_eof   (fifo_eof),
    .out_data   (out_data),
    .out_keep   (out_keep),
    .out_last   (out_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  logic [W-1:0] src[$];     // bytes not yet written into the FIFO
  logic [W-1:0] fq[$];      // FIFO contents
  logic [W-1:0] stream[$];  // whole byte stream of the scenario
  word_t        got[$];     // words accepted at the output
  word_t        exp[$];     // words predicted by the model
  int           acc_cyc[$]; // cycle number of each acceptance

  bit pend;                 // a pop was executed at the last edge
  bit eof_req;              // writer has finished the stream
  int wr_pct    = 100;
  int ready_pct = 100;
  int popped, bad_pop, cyc;
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the stream cut into RATIO-byte chunks, first byte in
  // the low slot; a short tail chunk is marked last with its keep mask.
  task automatic build_exp();
    exp.delete();
    for (int base = 0; base < stream.size(); base += R) begin
      word_t w;
      w = '0;
      for (int j = 0; j < R; j++) begin
        if (base + j < stream.size()) begin
          w.data[j*W +: W] = stream[base+j];
          w.keep[j]        = 1'b1;
        end
      end
      w.last = (stream.size() - base) < R;
      exp.push_back(w);
    end
  endtask

  // One clock of the FIFO model and output monitor; inputs change on the
  // falling edge, the DUT samples them on the next rising edge.
  task automatic step();
    word_t w;
    @(negedge clk);
    // NOTE: the bench drives with blocking assignments away from the active
    // edge, so the DUT always samples settled inputs.
    rst = 1'b0;
    cyc++;
    fifo_valid = pend;
    if (pend) begin
      if (fq.size() == 0) begin
        bad_pop++;
        fifo_data = '0;
      end else begin
        fifo_data = fq.pop_front();
      end
      popped++;
    end else begin
      fifo_data = W'($urandom);
    end
    if (src.size() > 0 && $urandom_range(99) < wr_pct) fq.push_back(src.pop_front());
    fifo_empty = (fq.size() == 0);
    fifo_eof   = eof_req && (src.size() == 0) && (fq.size() == 0) && !fifo_valid;
    out_ready  = ($urandom_range(99) < ready_pct);
    #1;
    pend = fifo_r_en;
    if (fifo_r_en && fq.size() == 0) bad_pop++;
    if (out_valid && out_ready) begin
      w.data = out_data;
      w.keep = out_keep;
      w.last = out_last;
      got.push_back(w);
      acc_cyc.push_back(cyc);
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    pend       = 1'b0;
    eof_req    = 1'b0;
    fifo_valid = 1'b0;
    fifo_empty = 1'b1;
    fifo_eof   = 1'b0;
    out_ready  = 1'b0;
    src.delete(); fq.delete(); got.delete(); acc_cyc.delete();
    popped = 0; bad_pop = 0; cyc = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start(input bit preload);
    do_reset();
    foreach (stream[i]) begin
      if (preload) fq.push_back(stream[i]);
      else         src.push_back(stream[i]);
    end
    build_exp();
  endtask

  task automatic run_until_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fifo_empty = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0)  begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== '0)     begin n_bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_cmp++; if (out_keep !== '0)     begin n_bad++; $display("FAIL reset_out_keep: got %h want 0", out_keep); end
    n_cmp++; if (out_last !== 1'b0)   begin n_bad++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    n_cmp++; if (done !== 1'b0)       begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (err !== 1'b0)        begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++; if (word_count !== '0)   begin n_bad++; $display("FAIL reset_word_count: got %0d want 0", word_count); end
    n_cmp++; if (fifo_r_en !== 1'b0)  begin n_bad++; $display("FAIL reset_r_en: got %b want 0", fifo_r_en); end
    fifo_empty = 1'b1;
  endtask

  task automatic test_full_words();
    bit ok;
    stream = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    start(1'b0);
    wr_pct = 100; ready_pct = 100; eof_req = 1'b1;
    run_until_done(200, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL full_done_timeout: got %b want 1", ok); end
    n_cmp++; if (got.size() !== exp.size()) begin n_bad++; $display("FAIL full_count: got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      n_cmp++; if (got[i] !== exp[i]) begin n_bad++; $display("FAIL full_word%0d: got %h want %h", i, got[i], exp[i]); end
    end
    if (got.size() > 0) begin
      n_cmp++; if (got[0].data !== 32'h44332211) begin n_bad++; $display("FAIL full_first_literal: got %h want 44332211", got[0].data); end
    end
    n_cmp++; if (word_count !== 2) begin n_bad++; $display("FAIL full_word_count: got %0d want 2", word_count); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL full_err: got %b want 0", err); end
  endtask

  task automatic test_partial();
    bit ok;
    stream = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    start(1'b0);
    wr_pct = 100; ready_pct = 100; eof_req = 1'b1;
    run_until_done(200, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL partial_done_timeout: got %b want 1", ok); end
    n_cmp++; if (got.size() !== exp.size()) begin n_bad++; $display("FAIL partial_count: got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      n_cmp++; if (got[i] !== exp[i]) begin n_bad++; $display("FAIL partial_word%0d: got %h want %h", i, got[i], exp[i]); end
    end
    n_cmp++; if (word_count !== 2) begin n_bad++; $display("FAIL partial_word_count: got %0d want 2", word_count); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int unstable;
    unstable = 0;
    stream = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    start(1'b1);
    ready_pct = 0; eof_req = 1'b0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (out_valid && out_data !== 32'h44332211) unstable++;
    end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid: got %b want 1", out_valid); end
    n_cmp++; if (unstable !== 0) begin n_bad++; $display("FAIL bp_stable: got %0d changed cycles want 0", unstable); end
    n_cmp++; if (popped !== 2*R) begin n_bad++; $display("FAIL bp_popped: got %0d want %0d", popped, 2*R); end
    n_cmp++; if (fifo_r_en !== 1'b0) begin n_bad++; $display("FAIL bp_r_en: got %b want 0", fifo_r_en); end
    ready_pct = 100;
    step(); step();
    n_cmp++; if (got.size() !== 2) begin n_bad++; $display("FAIL bp_release_count: got %0d want 2", got.size()); end
    if (got.size() == 2) begin
      n_cmp++; if (got[1] !== exp[1]) begin n_bad++; $display("FAIL bp_second_word: got %h want %h", got[1], exp[1]); end
      n_cmp++; if (acc_cyc[1] - acc_cyc[0] !== 1) begin n_bad++; $display("FAIL bp_second_gap: got %0d want 1", acc_cyc[1] - acc_cyc[0]); end
    end
    eof_req = 1'b1;
    run_until_done(50, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL bp_done_timeout: got %b want 1", ok); end
    n_cmp++; if (word_count !== 2) begin n_bad++; $display("FAIL bp_word_count: got %0d want 2", word_count); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    stream.delete();
    for (int i = 0; i < 4*R; i++) stream.push_back(W'($urandom));
    start(1'b1);
    ready_pct = 100; eof_req = 1'b1;
    run_until_done(300, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL b2b_done_timeout: got %b want 1", ok); end
    n_cmp++; if (got.size() !== exp.size()) begin n_bad++; $display("FAIL b2b_count: got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      n_cmp++; if (got[i] !== exp[i]) begin n_bad++; $display("FAIL b2b_word%0d: got %h want %h", i, got[i], exp[i]); end
    end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      n_cmp++; if (acc_cyc[i] - acc_cyc[i-1] !== R + 2) begin n_bad++; $display("FAIL b2b_period%0d: got %0d want %0d", i, acc_cyc[i] - acc_cyc[i-1], R + 2); end
    end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL b2b_err: got %b want 0", err); end
    n_cmp++; if (bad_pop !== 0) begin n_bad++; $display("FAIL b2b_bad_pop: got %0d want 0", bad_pop); end
  endtask

  task automatic test_midpack_reset();
    bit ok;
    logic [W-1:0] all[$];
    stream.delete();
    for (int i = 0; i < 2*R; i++) stream.push_back(W'($urandom));
    all = stream;
    start(1'b1);
    ready_pct = 100; eof_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (popped == 2) break;
    end
    n_cmp++; if (popped !== 2 || pend !== 1'b1) begin n_bad++; $display("FAIL mid_setup: got popped=%0d pend=%b want 2/1", popped, pend); end
    // Idx is now 2 after this edge and a third pop is in flight.
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_cmp++; if ({out_valid, out_last, done, err, fifo_r_en} !== 5'b0) begin n_bad++; $display("FAIL mid_async_flags: got %b want 00000", {out_valid, out_last, done, err, fifo_r_en}); end
    n_cmp++; if (out_data !== '0 || out_keep !== '0 || word_count !== '0) begin n_bad++; $display("FAIL mid_async_regs: got %h/%h/%0d want 0/0/0", out_data, out_keep, word_count); end
    got.delete(); acc_cyc.delete();
    // The stale third word is dropped; the rest of the stream packs afresh.
    stream.delete();
    for (int i = 3; i < all.size(); i++) stream.push_back(all[i]);
    build_exp();
    step(); step();
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL mid_stale_err: got %b want 1", err); end
    eof_req = 1'b1;
    run_until_done(200, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL mid_done_timeout: got %b want 1", ok); end
    n_cmp++; if (got.size() !== exp.size()) begin n_bad++; $display("FAIL mid_count: got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      n_cmp++; if (got[i] !== exp[i]) begin n_bad++; $display("FAIL mid_word%0d: got %h want %h", i, got[i], exp[i]); end
    end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL mid_err_sticky: got %b want 1", err); end
  endtask

  task automatic test_empty();
    int  n;
    bit  seen_valid;
    n = 0; seen_valid = 1'b0;
    stream.delete();
    start(1'b0);
    ready_pct = 100; eof_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n++;
      if (out_valid) seen_valid = 1'b1;
      if (done) break;
    end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL empty_done: got %b want 1 after %0d cycles", done, n); end
    n_cmp++; if (seen_valid !== 1'b0) begin n_bad++; $display("FAIL empty_valid: got %b want 0", seen_valid); end
    n_cmp++; if (word_count !== 0) begin n_bad++; $display("FAIL empty_word_count: got %0d want 0", word_count); end
  endtask

  task automatic test_random();
    bit ok;
    int len;
    for (int it = 0; it < 12; it++) begin
      len = $urandom_range(0, 6*R - 1);
      stream.delete();
      for (int i = 0; i < len; i++) stream.push_back(W'($urandom));
      start(1'b0);
      wr_pct    = $urandom_range(30, 100);
      ready_pct = $urandom_range(30, 100);
      eof_req   = 1'b1;
      run_until_done(3000, ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rnd%0d_done_timeout: got %b want 1", it, ok); end
      n_cmp++; if (got.size() !== exp.size()) begin n_bad++; $display("FAIL rnd%0d_count: got %0d want %0d", it, got.size(), exp.size()); end
      for (int i = 0; i < got.size() && i < exp.size(); i++) begin
        n_cmp++; if (got[i] !== exp[i]) begin n_bad++; $display("FAIL rnd%0d_word%0d: got %h want %h", it, i, got[i], exp[i]); end
      end
      n_cmp++; if (word_count !== CW'(exp.size())) begin n_bad++; $display("FAIL rnd%0d_word_count: got %0d want %0d", it, word_count, exp.size()); end
      n_cmp++; if (err !== 1'b0 || bad_pop !== 0) begin n_bad++; $display("FAIL rnd%0d_protocol: got err=%b bad_pop=%0d want 0/0", it, err, bad_pop); end
    end
  endtask

  initial begin
    test_reset();
    test_full_words();
    test_partial();
    test_backpressure();
    test_back_to_back();
    test_midpack_reset();
    test_empty();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
